// File: rtl/efpga_accel_if.sv
// Core <-> eFPGA accelerator link. The core side drives the operands and strobe,
// and the fabric side returns the results and the done/overrun status.
interface efpga_accel_if #(
   parameter int DATA_W  = 32,
   parameter int DELAY_W = 4
) ();
   logic               en_i;
   logic               write_strobe_i;
   logic [DATA_W-1:0]  operand_a_i;
   logic [DATA_W-1:0]  operand_b_i;
   logic [1:0]         operator_i;
   logic [DELAY_W-1:0] delay_i;
   logic [DATA_W-1:0]  result_a_o;
   logic [DATA_W-1:0]  result_b_o;
   logic [DATA_W-1:0]  result_c_o;
   logic               fpga_done_o;
   logic               overrun_o;

   modport master (
      output en_i, write_strobe_i, operand_a_i, operand_b_i, operator_i, delay_i,
      input  result_a_o, result_b_o, result_c_o, fpga_done_o, overrun_o
   );

   modport slave (
      input  en_i, write_strobe_i, operand_a_i, operand_b_i, operator_i, delay_i,
      output result_a_o, result_b_o, result_c_o, fpga_done_o, overrun_o
   );
endinterface

// File: rtl/efpga_accel_responder.sv
// Soft model of the eFPGA fabric: latches one operation, stays busy for the
// programmed delay, then publishes three results and raises done.
module efpga_accel_responder #(
   parameter int DATA_W  = 32,
   parameter int DELAY_W = 4
) (
   input  logic         clk,
   input  logic         reset,
   efpga_accel_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state;
   logic [DELAY_W-1:0] cnt;
   logic [DATA_W-1:0]  a_p0;
   logic [DATA_W-1:0]  b_p0;
   logic [1:0]         op_p0;
   logic [DATA_W-1:0]  res_a_q;
   logic [DATA_W-1:0]  res_b_q;
   logic [DATA_W-1:0]  res_c_q;
   logic               done_q;
   logic               overrun_q;
   logic               accept;
   logic [3*DATA_W-1:0] res_nxt;

   function automatic logic [3*DATA_W-1:0] op_result(
      input logic [1:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [DATA_W:0]        sum;
      logic [2*DATA_W-1:0]    prod;
      logic signed [DATA_W-1:0] sa;
      logic signed [DATA_W-1:0] sb;
      logic [DATA_W-1:0]      ra;
      logic [DATA_W-1:0]      rb;
      logic [DATA_W-1:0]      rc;
      sum  = {1'b0, a} + {1'b0, b};
      prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      sa   = a;
      sb   = b;
      ra   = a & b;
      rb   = a | b;
      rc   = a ^ b;
      case (op)
         2'b00: begin
            ra = sum[DATA_W-1:0];
            rb = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
            rc = a ^ b;
         end
         2'b01: begin
            ra = a - b;
            rb = {{(DATA_W-1){1'b0}}, (a < b)};
            rc = {{(DATA_W-1){1'b0}}, (sa < sb)};
         end
         2'b10: begin
            ra = prod[DATA_W-1:0];
            rb = prod[2*DATA_W-1:DATA_W];
            rc = '0;
         end
         default: ;
      endcase
      return {rc, rb, ra};
   endfunction

   assign accept  = (state == IDLE) && bus.en_i && bus.write_strobe_i;
   // Results are combinational from the holding registers; only the completion edge registers them.
   assign res_nxt = op_result(op_p0, a_p0, b_p0);

   // p0: operand holding registers, loaded on an accepted strobe
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0  <= bus.operand_a_i;
         b_p0  <= bus.operand_b_i;
         op_p0 <= bus.operator_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         res_a_q   <= '0;
         res_b_q   <= '0;
         res_c_q   <= '0;
         done_q    <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= BUSY;
                  cnt    <= bus.delay_i;
                  done_q <= 1'b0;
               end
            end
            BUSY: begin
               if (!bus.en_i) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end else begin
                  if (bus.write_strobe_i) overrun_q <= 1'b1;
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else begin
                     res_a_q <= res_nxt[DATA_W-1:0];
                     res_b_q <= res_nxt[2*DATA_W-1:DATA_W];
                     res_c_q <= res_nxt[3*DATA_W-1:2*DATA_W];
                     state   <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result_a_o  = res_a_q;
   assign bus.result_b_o  = res_b_q;
   assign bus.result_c_o  = res_c_q;
   assign bus.fpga_done_o = done_q;
   assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_efpga_accel_responder.sv
// Directed bench for efpga_accel_responder: a cycle-level reference model is
// compared every cycle, plus literal expectations at the key points.
module tb_efpga_accel_responder;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   efpga_accel_if #(.DATA_W(32), .DELAY_W(4)) bus ();

   efpga_accel_responder #(.DATA_W(32), .DELAY_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected {c,b,a} straight from the operation table.
   function automatic logic [95:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [63:0] p;
      case (op)
         2'd0: begin
            s = {1'b0, a} + {1'b0, b};
            return {a ^ b, {31'b0, s[32]}, s[31:0]};
         end
         2'd1: return {{31'b0, ($signed(a) < $signed(b))}, {31'b0, (a < b)}, a - b};
         2'd2: begin
            p = 64'(a) * 64'(b);
            return {32'h0, p};
         end
         default: return {a ^ b, a | b, a & b};
      endcase
   endfunction

   // Reference model: tracks the completion edge number rather than a countdown.
   logic        m_busy;
   int          m_finish;
   logic [95:0] m_pend;
   logic [95:0] m_res;
   logic        m_ovr;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_busy = 1'b0;
         m_res  = '0;
         m_ovr  = 1'b0;
      end else if (!m_busy) begin
         if (bus.en_i && bus.write_strobe_i) begin
            m_busy   = 1'b1;
            m_finish = cyc + 1 + int'(bus.delay_i);
            m_pend   = ref_op(bus.operator_i, bus.operand_a_i, bus.operand_b_i);
         end
      end else if (!bus.en_i) begin
         m_busy = 1'b0;
      end else begin
         if (bus.write_strobe_i) m_ovr = 1'b1;
         if (cyc == m_finish) begin
            m_busy = 1'b0;
            m_res  = m_pend;
         end
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("model_done",    64'(bus.fpga_done_o), 64'(!m_busy));
         chk("model_overrun", 64'(bus.overrun_o),   64'(m_ovr));
         chk("model_res_a",   64'(bus.result_a_o),  64'(m_res[31:0]));
         chk("model_res_b",   64'(bus.result_b_o),  64'(m_res[63:32]));
         chk("model_res_c",   64'(bus.result_c_o),  64'(m_res[95:64]));
      end
   end

   // Drives one strobe cycle; returns at the negedge opening cycle T+1.
   task automatic strobe(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] d);
      bus.en_i           = 1'b1;
      bus.write_strobe_i = 1'b1;
      bus.operator_i     = op;
      bus.operand_a_i    = a;
      bus.operand_b_i    = b;
      bus.delay_i        = d;
      @(negedge clk);
      bus.write_strobe_i = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.fpga_done_o !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic chk_res(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      chk({name, "_a"}, 64'(bus.result_a_o), 64'(a));
      chk({name, "_b"}, 64'(bus.result_b_o), 64'(b));
      chk({name, "_c"}, 64'(bus.result_c_o), 64'(c));
   endtask

   initial begin
      int n;
      reset              = 1'b1;
      bus.en_i           = 1'b0;
      bus.write_strobe_i = 1'b0;
      bus.operator_i     = 2'd0;
      bus.operand_a_i    = '0;
      bus.operand_b_i    = '0;
      bus.delay_i        = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.en_i           = 1'b1;
         bus.write_strobe_i = ~bus.write_strobe_i;
         bus.operand_a_i    = 32'hDEAD_0000 + 32'(i);
      end
      @(negedge clk);
      reset              = 1'b0;
      bus.write_strobe_i = 1'b0;
      chk_res("reset", 32'h0, 32'h0, 32'h0);
      chk("reset_done",    64'(bus.fpga_done_o), 64'd1);
      chk("reset_overrun", 64'(bus.overrun_o),   64'd0);
      @(negedge clk);

      // ADD with carry out, no extra delay
      strobe(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 4'd0);
      chk("add_busy", 64'(bus.fpga_done_o), 64'd0);
      wait_done(n);
      chk("add_latency", 64'(n), 64'd1);
      chk_res("add", 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFD);
      @(negedge clk);

      // MUL, delay 5
      strobe(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 4'd5);
      wait_done(n);
      chk("mul_latency", 64'(n), 64'd6);
      chk_res("mul", 32'h242D_2080, 32'h0B00_EA4E, 32'h0);
      @(negedge clk);

      // SUB: borrow set, signed compare clear
      strobe(2'b01, 32'h0000_0001, 32'h8000_0000, 4'd3);
      wait_done(n);
      chk("sub_latency", 64'(n), 64'd4);
      chk_res("sub", 32'h8000_0001, 32'h0000_0001, 32'h0);
      @(negedge clk);

      // LOGIC delay 10, overrun strobe at T+3, abort at T+6
      strobe(2'b11, 32'hAAAA_5555, 32'h0F0F_F0F0, 4'd10);
      repeat (2) @(negedge clk);
      bus.write_strobe_i = 1'b1;
      bus.operand_a_i    = 32'h1111_1111;
      @(negedge clk);
      bus.write_strobe_i = 1'b0;
      chk("ovr_set", 64'(bus.overrun_o), 64'd1);
      chk("ovr_still_busy", 64'(bus.fpga_done_o), 64'd0);
      repeat (2) @(negedge clk);
      bus.en_i = 1'b0;
      @(negedge clk);
      chk("abort_done", 64'(bus.fpga_done_o), 64'd1);
      chk_res("abort", 32'h8000_0001, 32'h0000_0001, 32'h0);

      // Strobe while disabled is ignored
      bus.write_strobe_i = 1'b1;
      @(negedge clk);
      bus.write_strobe_i = 1'b0;
      @(negedge clk);
      chk("dis_done", 64'(bus.fpga_done_o), 64'd1);
      chk_res("dis", 32'h8000_0001, 32'h0000_0001, 32'h0);

      // Reset in the middle of a delay-8 op
      strobe(2'b00, 32'h0000_0005, 32'h0000_0007, 4'd8);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_res("midreset", 32'h0, 32'h0, 32'h0);
      chk("midreset_done",    64'(bus.fpga_done_o), 64'd1);
      chk("midreset_overrun", 64'(bus.overrun_o),   64'd0);
      @(negedge clk);

      // LOGIC op completing normally
      strobe(2'b11, 32'hF0F0_F0F0, 32'h0FF0_FF00, 4'd2);
      wait_done(n);
      chk("logic_latency", 64'(n), 64'd3);
      chk_res("logic", 32'h00F0_F000, 32'hFFF0_FFF0, 32'hFF00_0FF0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
